// File: rtl/inst_mem_responder.sv
// Instruction memory responder: fixed wait-state fetch FSM plus a byte-wide program-load port.
// Define FETCH_ADDR_CHECK_EN to flag misaligned or out-of-range fetches on resp_err.
module inst_mem_responder #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [7:0]  ld_data
);

  localparam int unsigned AddrW   = $clog2(DEPTH_BYTES);
  localparam int unsigned IdxW    = AddrW - 2;
  localparam logic [3:0]  CntInit = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

  stateT           stateQ, stateD;
  logic [3:0]      cntQ, cntD;
  logic [IdxW-1:0] wordIdxQ;
  logic [31:0]     respDataQ;
  logic [31:0]     fetchWord;
  logic            accept, enterResp;
  logic [7:0]      mem [DEPTH_BYTES];

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    accept    = 1'b0;
    enterResp = 1'b0;
    busy      = 1'b0;
    unique case (stateQ)
      StIdle: begin
        busy = req_valid;
        if (req_valid) begin
          accept = 1'b1;
          cntD   = CntInit;
          stateD = StWait;
        end
      end
      StWait: begin
        busy = 1'b1;
        if (cntQ == 4'd0) begin
          enterResp = 1'b1;
          stateD    = StResp;
        end else begin
          cntD = cntQ - 4'd1;
        end
      end
      StResp:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Storage is deliberately outside the reset domain so a program survives rst.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr[AddrW-1:0]] <= ld_data;
    end
  end

  assign fetchWord = {mem[{wordIdxQ, 2'd3}], mem[{wordIdxQ, 2'd2}],
                      mem[{wordIdxQ, 2'd1}], mem[{wordIdxQ, 2'd0}]};

`ifdef FETCH_ADDR_CHECK_EN
  logic addrBad, addrBadQ, respErrQ;

  assign addrBad = (req_addr[1:0] != 2'b00) ||
                   (({1'b0, req_addr} + 33'd3) >= 33'(DEPTH_BYTES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrBadQ <= 1'b0;
      respErrQ <= 1'b0;
    end else begin
      if (accept) begin
        addrBadQ <= addrBad;
      end
      respErrQ <= enterResp & addrBadQ;
    end
  end

  assign resp_err = respErrQ;
`else
  logic unusedAddrBits;
  assign unusedAddrBits = ^{req_addr[31:AddrW], req_addr[1:0]};
  assign resp_err       = 1'b0;
`endif

  logic unusedLdBits;
  assign unusedLdBits = ^ld_addr[31:AddrW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ    <= StIdle;
      cntQ      <= 4'd0;
      wordIdxQ  <= '0;
      respDataQ <= 32'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (accept) begin
        wordIdxQ <= req_addr[AddrW-1:2];
      end
      // Read happens on the RESP-entry edge, so a same-edge load is not yet visible.
      if (enterResp) begin
`ifdef FETCH_ADDR_CHECK_EN
        respDataQ <= addrBadQ ? 32'd0 : fetchWord;
`else
        respDataQ <= fetchWord;
`endif
      end
    end
  end

  assign resp_valid = (stateQ == StResp);
  assign resp_data  = respDataQ;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench for inst_mem_responder: a timing/byte-array model predicts each response,
// a negedge monitor pops and compares whenever resp_valid is seen.
module tb_inst_mem_responder;

  localparam int unsigned Depth = 256;
  localparam int unsigned W     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = 32'd0;
  logic [7:0]  ld_data = 8'd0;
  logic        busy, resp_valid, resp_err;
  logic [31:0] resp_data;

  inst_mem_responder #(.DEPTH_BYTES(Depth), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .busy      (busy),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned at;
  } expT;

  expT         expQ[$];
  expT         head;
  logic [7:0]  model [Depth];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned accEdge = 0;
  bit          live = 1'b0;
  logic [31:0] accAddr = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic expT predict(input logic [31:0] a, input int unsigned at);
    expT         r;
    int unsigned b;
    r.at  = at;
    r.err = 1'b0;
    b = ((a >> 2) % (Depth / 4)) * 4;
    r.data = {model[b+3], model[b+2], model[b+1], model[b]};
`ifdef FETCH_ADDR_CHECK_EN
    if (a[1:0] != 2'b00 || ({1'b0, a} + 33'd3) >= 33'(Depth)) begin
      r.err  = 1'b1;
      r.data = 32'd0;
    end
`endif
    return r;
  endfunction

  // One clock cycle: drive inputs at negedge and advance the model for the coming edge.
  task automatic step(input bit rstn, input bit req, input logic [31:0] addr,
                      input bit ld, input logic [31:0] la, input logic [7:0] ldat);
    int unsigned e;
    bit          inWait, idle;
    @(negedge clk);
    e = cyc + 1;
    if (live && e >= accEdge + W + 2) live = 1'b0;
    // Avoid dropping reset in the middle of a visible response cycle.
    if (!rstn && live && e == accEdge + W + 1) rstn = 1'b1;
    if (!rstn) live = 1'b0;
    rst       = rstn;
    req_valid = req;
    req_addr  = addr;
    ld_en     = ld;
    ld_addr   = la;
    ld_data   = ldat;
    inWait = live && (e <= accEdge + W);
    idle   = !live;
    #1 check("busy", {31'd0, busy}, {31'd0, inWait | (idle & req)});
    if (live && e == accEdge + W) expQ.push_back(predict(accAddr, e));
    if (idle && req && rstn) begin
      live    = 1'b1;
      accEdge = e;
      accAddr = addr;
    end
    if (ld) model[la % Depth] = ldat;
  endtask

  task automatic idleSteps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0);
  endtask

  task automatic fetch(input logic [31:0] a);
    step(1'b1, 1'b1, a, 1'b0, 32'd0, 8'd0);
    idleSteps(W + 2);
  endtask

  task automatic load(input logic [31:0] a, input logic [7:0] d);
    step(1'b1, 1'b0, 32'd0, 1'b1, a, d);
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
      end else begin
        head = expQ.pop_front();
        check("resp_cycle", cyc, head.at);
        check("resp_data", resp_data, head.data);
        check("resp_err", {31'd0, resp_err}, {31'd0, head.err});
      end
    end
  end

  initial begin
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);

    for (int i = 0; i < Depth; i++) load(32'(i), 8'($urandom));
    load(32'd0, 8'h01); load(32'd1, 8'hA0); load(32'd2, 8'hD0); load(32'd3, 8'hE3);
    load(32'd4, 8'hFF); load(32'd5, 8'hFF); load(32'd6, 8'hFF); load(32'd7, 8'hEA);

    fetch(32'd0);
    check("aligned_hold", resp_data, 32'hE3D0A001);

    for (int i = 0; i < 2 * (W + 2); i++) begin
      step(1'b1, 1'b1, (i < W + 2) ? 32'd0 : 32'd4, 1'b0, 32'd0, 8'd0);
    end
    idleSteps(W + 2);
    check("b2b_hold", resp_data, 32'hEAFFFFFF);

    step(1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 8'd0);
    step(1'b0, 1'b1, 32'd8, 1'b0, 32'd0, 8'd0);
    step(1'b0, 1'b0, 32'd8, 1'b0, 32'd0, 8'd0);
    idleSteps(W + 2);
    check("rst_abort_data", resp_data, 32'd0);
    fetch(32'd0);
    check("retained_hold", resp_data, 32'hE3D0A001);

    step(1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 8'd0);
    for (int i = 0; i < W - 1; i++) idleSteps(1);
    load(32'd0, 8'hFF);
    idleSteps(W + 1);
    check("collision_hold", resp_data, 32'hE3D0A001);
    fetch(32'd0);
    check("post_collision_hold", resp_data, 32'hE3D0A0FF);

    fetch(32'd2);
`ifdef FETCH_ADDR_CHECK_EN
    check("bad_addr_hold", resp_data, 32'd0);
`else
    check("bad_addr_hold", resp_data, 32'hE3D0A0FF);
`endif
    fetch(32'(Depth + 4));

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a, la;
      a  = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(Depth + 8));
      la = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(Depth - 1));
      step($urandom_range(99) != 0, 1'($urandom_range(1)), a,
           $urandom_range(2) == 0, la, 8'($urandom));
    end
    idleSteps(W + 3);
    check("queue_empty", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
